pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h00004180, SHALL be the PC target for any trap redirect.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 stall  input  1  SHALL mean the pipeline cannot accept a fetched instruction this cycle.
REQ-006 branchValid / branchTarget  input  1 / 32  SHALL carry a branch redirect request and its target.
REQ-007 jumpValid / jumpTarget  input  1 / 32  SHALL carry a jump redirect request and its target.
REQ-008 trapValid  input  1  SHALL request a redirect to TRAP_VECTOR.
REQ-009 fetchReq  output  1  SHALL request an instruction-memory read at fetchAddr.
REQ-010 fetchAck  input  1  SHALL indicate the memory has accepted and completed the current fetch.
REQ-011 fetchAddr  output  32  SHALL equal pcValue combinationally.
REQ-012 pcValue  output  32  SHALL hold the current program counter.
REQ-013 redirectTaken  output  1  SHALL pulse for one cycle when pcValue is loaded from a redirect.
REQ-014 misalignTrap  output  1  SHALL pulse for one cycle when a redirect target is converted to a trap.

Function
REQ-015 FSM states SHALL be IDLE, REQ and HOLD.
REQ-016 IDLE SHALL last exactly one cycle after reset release, with fetchReq=0, then go to REQ.
REQ-017 In REQ, fetchReq SHALL be 1; without fetchAck, state and pcValue SHALL hold.
REQ-018 In REQ with fetchAck and stall=0, pcValue SHALL take the next PC (pending redirect, else pcValue+4) and remain in REQ.
REQ-019 In REQ with fetchAck and stall=1, pcValue SHALL take the next PC and go to HOLD.
REQ-020 In HOLD, fetchReq SHALL be 0; the FSM SHALL return to REQ the cycle after stall=0.
REQ-021 Redirect priority in one cycle SHALL be trap > jump > branch.
REQ-022 A redirect arriving in REQ SHALL be latched as pending and applied at the next fetchAck, never aborting the in-flight fetch.
REQ-023 A redirect arriving in the same cycle as fetchAck SHALL be applied at that fetchAck.
REQ-024 A new redirect SHALL overwrite the pending one, except that a non-trap SHALL never overwrite a pending trap.
REQ-025 A redirect arriving in HOLD or IDLE SHALL load pcValue at the next edge and clear any pending redirect.
REQ-026 redirectTaken SHALL pulse on the same edge that pcValue loads a redirect target.
REQ-027 Sequential increment SHALL be modulo 2^32, so 32'hFFFFFFFC advances to 32'h00000000.

Reset
REQ-028 On reset, pcValue SHALL be RESET_PC, state IDLE, fetchReq 0, redirectTaken 0, misalignTrap 0, and pending cleared.
REQ-029 Reset SHALL override all inputs, including mid-fetch: fetchReq SHALL be 0 the cycle after reset is sampled, and the in-flight fetch is discarded.

Configuration
REQ-030 With PC_SEQ_MISALIGN_TRAP_EN defined, a jump or branch target with bits [1:0]!=0 SHALL become a trap redirect to TRAP_VECTOR and pulse misalignTrap when applied.
REQ-031 Without PC_SEQ_MISALIGN_TRAP_EN, target bits [1:0] SHALL be forced to 2'b00, and misalignTrap SHALL be tied to 0.

Structure
REQ-032 Package pc_seq_pkg SHALL hold the FSM state encoding, the redirect-source encoding (NONE/BRANCH/JUMP/TRAP), and the RESET_PC and TRAP_VECTOR defaults.
REQ-033 Sub-module pc_redirect_arbiter SHALL implement combinational priority selection plus the misalign check/mask; the sequencer SHALL hold the FSM, PC and pending registers.

Verification
REQ-034 Reset, then fetchAck every cycle with stall=0 -> IDLE 1 cycle, then pcValue 0x3000, 0x3004, 0x3008.
REQ-035 Load pcValue 0x3010 via a HOLD-state jump, release stall, fetchAck delayed 3 cycles, jumpValid=1/jumpTarget=0x3100 in the 1st wait cycle -> pcValue holds 0x3010; at ack pcValue=0x3100 and redirectTaken=1.
REQ-036 trapValid, jumpValid (0x5000) and branchValid (0x6000) asserted in the same cycle -> pcValue=0x4180; a later branch before ack does not replace the pending trap.
REQ-037 Stall=1 at ack from 0x3020 -> HOLD with pcValue 0x3024 and fetchReq=0; branch to 0x3200 in HOLD -> pcValue 0x3200 next edge; stall=0 -> REQ at 0x3200.
REQ-038 Macro defined, jumpTarget 0x3102 -> pcValue 0x4180 and misalignTrap=1; macro undefined -> pcValue 0x3100 and misalignTrap=0.
REQ-039 Force pcValue 0xFFFFFFFC via a jump, then ack -> pcValue 0x00000000; assert reset mid-wait -> fetchReq 0 next cycle and pcValue 0x3000.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: FSM state encoding,
// redirect-source encoding, the redirect request record and reset/trap addresses.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redirect_src_e;

    typedef struct packed {
        redirect_src_e src;
        logic          misalign;
        logic [31:0]   target;
    } redirect_t;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_3000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_4180;
    localparam redirect_t   NO_REDIRECT         = '{src: NONE, misalign: 1'b0, target: 32'h0};

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational trap > jump > branch selection plus target alignment handling.
// PC_SEQ_MISALIGN_TRAP_EN turns misaligned jump/branch targets into traps; otherwise they are masked.
module pc_redirect_arbiter
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic        branchValid,
    input  logic [31:0] branchTarget,
    input  logic        jumpValid,
    input  logic [31:0] jumpTarget,
    input  logic        trapValid,
    output redirect_t   redirect
);

    redirect_src_e raw_src;
    logic [31:0]   raw_target;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        raw_src    = NONE;
        raw_target = 32'h0;
        if (trapValid) begin
            raw_src    = TRAP;
            raw_target = TRAP_VECTOR;
        end else if (jumpValid) begin
            raw_src    = JUMP;
            raw_target = jumpTarget;
        end else if (branchValid) begin
            raw_src    = BRANCH;
            raw_target = branchTarget;
        end
    end

    always_comb begin
        redirect = '{src: raw_src, misalign: 1'b0, target: raw_target};
        if (raw_src == JUMP || raw_src == BRANCH) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            if (raw_target[1:0] != 2'b00) begin
                redirect = '{src: TRAP, misalign: 1'b1, target: TRAP_VECTOR};
            end
`else
            redirect.target[1:0] = 2'b00;
`endif
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: IDLE/REQ/HOLD fetch FSM, program counter and one pending redirect slot.
// Build option PC_SEQ_MISALIGN_TRAP_EN (handled in pc_redirect_arbiter) enables misalignment traps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchValid,
    input  logic [31:0] branchTarget,
    input  logic        jumpValid,
    input  logic [31:0] jumpTarget,
    input  logic        trapValid,
    output logic        fetchReq,
    input  logic        fetchAck,
    output logic [31:0] fetchAddr,
    output logic [31:0] pcValue,
    output logic        redirectTaken,
    output logic        misalignTrap
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    redirect_t   pend_q, pend_d;
    logic        redirect_taken_q, redirect_taken_d;
    logic        misalign_trap_q, misalign_trap_d;
    redirect_t   incoming;
    redirect_t   merged;

    pc_redirect_arbiter #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_arbiter (
        .branchValid  (branchValid),
        .branchTarget (branchTarget),
        .jumpValid    (jumpValid),
        .jumpTarget   (jumpTarget),
        .trapValid    (trapValid),
        .redirect     (incoming)
    );

    // A fresh request replaces the pending one unless that would demote a pending trap.
    always_comb begin
        merged = pend_q;
        if (incoming.src != NONE && !(pend_q.src == TRAP && incoming.src != TRAP)) begin
            merged = incoming;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pend_d           = pend_q;
        redirect_taken_d = 1'b0;
        misalign_trap_d  = 1'b0;
        fetchReq         = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pend_d  = NO_REDIRECT;
                if (incoming.src != NONE) begin
                    pc_d             = incoming.target;
                    redirect_taken_d = 1'b1;
                    misalign_trap_d  = incoming.misalign;
                end
            end
            REQ: begin
                fetchReq = 1'b1;
                if (fetchAck) begin
                    pend_d  = NO_REDIRECT;
                    state_d = stall ? HOLD : REQ;
                    if (merged.src != NONE) begin
                        pc_d             = merged.target;
                        redirect_taken_d = 1'b1;
                        misalign_trap_d  = merged.misalign;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    // The in-flight fetch is never aborted; the redirect waits for its ack.
                    pend_d = merged;
                end
            end
            HOLD: begin
                pend_d = NO_REDIRECT;
                if (incoming.src != NONE) begin
                    pc_d             = incoming.target;
                    redirect_taken_d = 1'b1;
                    misalign_trap_d  = incoming.misalign;
                end
                if (!stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            pend_q           <= NO_REDIRECT;
            redirect_taken_q <= 1'b0;
            misalign_trap_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pend_q           <= pend_d;
            redirect_taken_q <= redirect_taken_d;
            misalign_trap_q  <= misalign_trap_d;
        end
    end

    assign pcValue       = pc_q;
    assign fetchAddr     = pc_q;
    assign redirectTaken = redirect_taken_q;
    // Constant zero unless misalignment traps are built in, since the arbiter never flags one otherwise.
    assign misalignTrap  = misalign_trap_q;

endmodule
